// File: rtl/dm_mem_arbiter.sv
// dm_mem_arbiter: shares one memory port between the core data port (cpu_*)
// and the debug module master port (dbg_*). One requester is granted at a
// time; its request is registered onto mem_* and the single-cycle memory
// response is routed back to the granted requester only.
module dm_mem_arbiter #(
    parameter int unsigned S_OFFSET     = 2,
    parameter int unsigned S_MASK       = 2**S_OFFSET,
    parameter int unsigned S_LINE       = 8*S_MASK,
    parameter int unsigned DBG_PRIORITY = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_stb,
    input  logic              cpu_we,
    input  logic [S_MASK-1:0] cpu_mbe,
    input  logic [31:0]       cpu_address,
    input  logic [S_LINE-1:0] cpu_wdata,
    output logic              cpu_resp,
    output logic [S_LINE-1:0] cpu_rdata,

    input  logic              dbg_stb,
    input  logic              dbg_we,
    input  logic [S_MASK-1:0] dbg_mbe,
    input  logic [31:0]       dbg_address,
    input  logic [S_LINE-1:0] dbg_wdata,
    output logic              dbg_resp,
    output logic [S_LINE-1:0] dbg_rdata,

    output logic              mem_stb,
    output logic              mem_we,
    output logic [S_MASK-1:0] mem_mbe,
    output logic [31:0]       mem_address,
    output logic [S_LINE-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [S_LINE-1:0] mem_rdata
);

    localparam bit DBG_WINS = (DBG_PRIORITY != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DBG = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_dbg_q;   // 1: last grant went to dbg, 0: to cpu
    logic   last_dbg_d;
    logic   grant_cpu;
    logic   grant_dbg;

    // Arbitration, next state and same-cycle response routing
    always_comb begin
        state_d    = state_q;
        last_dbg_d = last_dbg_q;
        grant_cpu  = 1'b0;
        grant_dbg  = 1'b0;
        cpu_resp   = 1'b0;
        dbg_resp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_stb && dbg_stb) begin
                    // tie: fixed dbg priority, or the side not served last
                    if (DBG_WINS || !last_dbg_q) begin
                        grant_dbg = 1'b1;
                    end else begin
                        grant_cpu = 1'b1;
                    end
                end else if (dbg_stb) begin
                    grant_dbg = 1'b1;
                end else if (cpu_stb) begin
                    grant_cpu = 1'b1;
                end
                if (grant_dbg) begin
                    state_d    = GNT_DBG;
                    last_dbg_d = 1'b1;
                end else if (grant_cpu) begin
                    state_d    = GNT_CPU;
                    last_dbg_d = 1'b0;
                end
            end
            GNT_CPU: begin
                if (mem_resp) begin
                    cpu_resp = 1'b1;
                    state_d  = IDLE;
                end
            end
            GNT_DBG: begin
                if (mem_resp) begin
                    dbg_resp = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and round-robin history registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_dbg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dbg_q <= last_dbg_d;
        end
    end

    // Memory port request registers: captured at grant, held until response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_stb     <= 1'b0;
            mem_we      <= 1'b0;
            mem_mbe     <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else if (grant_cpu) begin
            mem_stb     <= 1'b1;
            mem_we      <= cpu_we;
            mem_mbe     <= cpu_mbe;
            mem_address <= cpu_address;
            mem_wdata   <= cpu_wdata;
        end else if (grant_dbg) begin
            mem_stb     <= 1'b1;
            mem_we      <= dbg_we;
            mem_mbe     <= dbg_mbe;
            mem_address <= dbg_address;
            mem_wdata   <= dbg_wdata;
        end else if ((state_q != IDLE) && mem_resp) begin
            mem_stb     <= 1'b0;
        end
    end

    // Read data is broadcast; each requester qualifies it with its own resp
    assign cpu_rdata = mem_rdata;
    assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Testbench for dm_mem_arbiter: a stimulus process drives both requesters and
// a memory slave model (pushing expected read data into a scoreboard); a
// monitor keeps a transaction-level reference of the arbitration rules and
// compares every cycle.
module tb_dm_mem_arbiter;

    localparam int unsigned S_OFFSET = 2;
    localparam int unsigned S_MASK   = 4;
    localparam int unsigned S_LINE   = 32;
    localparam int unsigned DBG_PRIO = 0;

    typedef struct {
        logic              we;
        logic [S_MASK-1:0] mbe;
        logic [31:0]       addr;
        logic [S_LINE-1:0] wdata;
    } txn_t;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main DUT signals (index 0 = cpu, 1 = dbg)
    logic              rst_i;
    logic              r_stb   [2];
    logic              r_we    [2];
    logic [S_MASK-1:0] r_mbe   [2];
    logic [31:0]       r_addr  [2];
    logic [S_LINE-1:0] r_wdata [2];
    logic              cpu_resp, dbg_resp;
    logic [S_LINE-1:0] cpu_rdata, dbg_rdata;
    logic              mem_stb, mem_we, mem_resp;
    logic [S_MASK-1:0] mem_mbe;
    logic [31:0]       mem_address;
    logic [S_LINE-1:0] mem_wdata, mem_rdata;

    dm_mem_arbiter #(.S_OFFSET(S_OFFSET), .S_MASK(S_MASK), .S_LINE(S_LINE),
                     .DBG_PRIORITY(DBG_PRIO)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_stb(r_stb[0]), .cpu_we(r_we[0]), .cpu_mbe(r_mbe[0]),
        .cpu_address(r_addr[0]), .cpu_wdata(r_wdata[0]),
        .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
        .dbg_stb(r_stb[1]), .dbg_we(r_we[1]), .dbg_mbe(r_mbe[1]),
        .dbg_address(r_addr[1]), .dbg_wdata(r_wdata[1]),
        .dbg_resp(dbg_resp), .dbg_rdata(dbg_rdata),
        .mem_stb(mem_stb), .mem_we(mem_we), .mem_mbe(mem_mbe),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    // fixed-priority instance
    logic              p_rst, p_cpu_stb, p_dbg_stb, p_cpu_resp, p_dbg_resp;
    logic [31:0]       p_cpu_address, p_dbg_address, p_mem_address;
    logic [S_LINE-1:0] p_cpu_rdata, p_dbg_rdata, p_mem_wdata, p_mem_rdata;
    logic              p_mem_stb, p_mem_we, p_mem_resp;
    logic [S_MASK-1:0] p_mem_mbe;

    dm_mem_arbiter #(.S_OFFSET(S_OFFSET), .S_MASK(S_MASK), .S_LINE(S_LINE),
                     .DBG_PRIORITY(1)) u_dut_prio (
        .clk_i(clk), .rst_i(p_rst),
        .cpu_stb(p_cpu_stb), .cpu_we(1'b0), .cpu_mbe(4'hF),
        .cpu_address(p_cpu_address), .cpu_wdata(32'h0),
        .cpu_resp(p_cpu_resp), .cpu_rdata(p_cpu_rdata),
        .dbg_stb(p_dbg_stb), .dbg_we(1'b0), .dbg_mbe(4'hF),
        .dbg_address(p_dbg_address), .dbg_wdata(32'h0),
        .dbg_resp(p_dbg_resp), .dbg_rdata(p_dbg_rdata),
        .mem_stb(p_mem_stb), .mem_we(p_mem_we), .mem_mbe(p_mem_mbe),
        .mem_address(p_mem_address), .mem_wdata(p_mem_wdata),
        .mem_resp(p_mem_resp), .mem_rdata(p_mem_rdata)
    );

    int          n_checks;
    int          n_fail;
    txn_t        cpu_todo[$];
    txn_t        dbg_todo[$];
    bit          on[2];
    bit          resp_seen[2];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] mem_arr [logic [31:0]];
    bit          req_rand, rand_lat, stray_now;
    int          mem_lat, m_cnt, cur_lat;
    int          n_resp[2];
    logic [31:0] last_rdata[2];
    logic [3:0]  last_mbe;
    logic        last_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int todo_size(input int i);
        return (i == 0) ? cpu_todo.size() : dbg_todo.size();
    endfunction

    task automatic todo_pop(input int i, output txn_t t);
        if (i == 0) t = cpu_todo.pop_front();
        else        t = dbg_todo.pop_front();
    endtask

    // One cycle of stimulus: memory slave model then both requesters
    task automatic tick();
        txn_t        t;
        logic [31:0] rd, nv;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
        if (stray_now) begin
            mem_resp  = 1'b1;
            stray_now = 1'b0;
        end else if (mem_stb === 1'b1) begin
            if (m_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
            if (m_cnt >= cur_lat) begin
                rd = mem_read(mem_address);
                if (mem_we) begin
                    nv = rd;
                    for (int b = 0; b < 4; b++)
                        if (mem_mbe[b]) nv[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_arr[mem_address] = nv;
                    rd = $urandom;
                end
                mem_rdata = rd;
                mem_resp  = 1'b1;
                exp_q.push_back(rd);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (resp_seen[i]) on[i] = 1'b0;
            if (!on[i]) begin
                if (todo_size(i) > 0 && (!req_rand || $urandom_range(0, 2) != 0)) begin
                    todo_pop(i, t);
                    r_stb[i] = 1'b1; r_we[i] = t.we; r_mbe[i] = t.mbe;
                    r_addr[i] = t.addr; r_wdata[i] = t.wdata;
                    on[i] = 1'b1;
                end else begin
                    r_stb[i] = 1'b0; r_we[i] = 1'($urandom); r_mbe[i] = 4'($urandom);
                    r_addr[i] = $urandom; r_wdata[i] = $urandom;
                end
            end else if (req_rand && $urandom_range(0, 7) == 0) begin
                r_addr[i]  = 32'($urandom_range(0, 15)) << 2;
                r_wdata[i] = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b1;
        cpu_todo.delete();
        dbg_todo.delete();
        for (int i = 0; i < 2; i++) begin
            on[i] = 1'b0;
            r_stb[i] = 1'b0;
        end
        m_cnt = 0;
        stray_now = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while ((cpu_todo.size() > 0 || dbg_todo.size() > 0 || on[0] || on[1]) && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL run_done: got timeout after %0d cycles, required completion", n);
        end
        tick();
        tick();
    endtask

    function automatic txn_t mk(input logic we, input logic [3:0] mbe,
                                input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.mbe = mbe; t.addr = a; t.wdata = d;
        return t;
    endfunction

    // Monitor: reference model of the arbitration rules plus scoreboard pop
    bit          m_busy, m_dbg, m_last_dbg, m_first, zero_chk;
    logic        cap_we;
    logic [3:0]  cap_mbe;
    logic [31:0] cap_addr, cap_wdata;
    initial begin
        logic [31:0] e;
        int          w;
        m_busy = 0; m_last_dbg = 0; zero_chk = 0;
        forever begin
            @(negedge clk);
            #2;
            resp_seen[0] = (cpu_resp === 1'b1);
            resp_seen[1] = (dbg_resp === 1'b1);
            chk("cpu_rdata_mirror", 64'(cpu_rdata), 64'(mem_rdata));
            chk("dbg_rdata_mirror", 64'(dbg_rdata), 64'(mem_rdata));
            if (rst_i === 1'b1) begin
                m_busy = 0; m_last_dbg = 0; zero_chk = 1;
                exp_q.delete();
            end else begin
                if (cpu_resp === 1'b1) begin n_resp[0]++; last_rdata[0] = cpu_rdata; end
                if (dbg_resp === 1'b1) begin n_resp[1]++; last_rdata[1] = dbg_rdata; end
                if (zero_chk) begin
                    chk("reset_mem_we", 64'(mem_we), 64'd0);
                    chk("reset_mem_mbe", 64'(mem_mbe), 64'd0);
                    chk("reset_mem_address", 64'(mem_address), 64'd0);
                    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
                    zero_chk = 0;
                end
                if (!m_busy) begin
                    chk("idle_mem_stb", 64'(mem_stb), 64'd0);
                    chk("idle_cpu_resp", 64'(cpu_resp), 64'd0);
                    chk("idle_dbg_resp", 64'(dbg_resp), 64'd0);
                    if (r_stb[0] === 1'b1 || r_stb[1] === 1'b1) begin
                        m_dbg = (r_stb[1] === 1'b1) &&
                                (r_stb[0] !== 1'b1 || DBG_PRIO != 0 || !m_last_dbg);
                        w = m_dbg ? 1 : 0;
                        cap_we = r_we[w]; cap_mbe = r_mbe[w];
                        cap_addr = r_addr[w]; cap_wdata = r_wdata[w];
                        m_last_dbg = m_dbg;
                        m_busy = 1; m_first = 1;
                    end
                end else begin
                    chk("busy_mem_stb", 64'(mem_stb), 64'd1);
                    chk("mem_we", 64'(mem_we), 64'(cap_we));
                    chk("mem_mbe", 64'(mem_mbe), 64'(cap_mbe));
                    chk("mem_address", 64'(mem_address), 64'(cap_addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(cap_wdata));
                    if (m_first) begin
                        obs_q.push_back(mem_address);
                        last_mbe = mem_mbe; last_we = mem_we;
                        m_first = 0;
                    end
                    if (mem_resp === 1'b1) begin
                        chk("cpu_resp_route", 64'(cpu_resp), 64'(!m_dbg));
                        chk("dbg_resp_route", 64'(dbg_resp), 64'(m_dbg));
                        if (exp_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL scoreboard_empty: got resp, required queued data");
                        end else begin
                            e = exp_q.pop_front();
                            chk("resp_rdata", 64'(m_dbg ? dbg_rdata : cpu_rdata), 64'(e));
                        end
                        m_busy = 0;
                    end else begin
                        chk("wait_cpu_resp", 64'(cpu_resp), 64'd0);
                        chk("wait_dbg_resp", 64'(dbg_resp), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence
    initial begin
        int          r0, r1, dcnt;
        logic [31:0] plog[$];
        logic [31:0] exp_pat[6];
        logic [31:0] p_pat[4];
        n_checks = 0; n_fail = 0;
        rst_i = 1'b1; mem_resp = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            r_stb[i] = 0; r_we[i] = 0; r_mbe[i] = 0; r_addr[i] = 0; r_wdata[i] = 0;
            on[i] = 0; resp_seen[i] = 0; n_resp[i] = 0; last_rdata[i] = 0;
        end
        req_rand = 0; rand_lat = 0; stray_now = 0; mem_lat = 0; m_cnt = 0; cur_lat = 0;
        p_rst = 1; p_cpu_stb = 0; p_dbg_stb = 0; p_cpu_address = 0; p_dbg_address = 0;
        p_mem_resp = 0; p_mem_rdata = 0;

        // single cpu read, 3-cycle memory
        do_reset();
        mem_arr[32'h100] = 32'hDEADBEEF;
        mem_lat = 2; obs_q.delete(); r1 = n_resp[1];
        cpu_todo.push_back(mk(1'b0, 4'hF, 32'h100, 32'h0));
        run_done(50);
        chk("t1_cpu_rdata", 64'(last_rdata[0]), 64'hDEADBEEF);
        chk("t1_no_dbg_resp", 64'(n_resp[1] - r1), 64'd0);
        chk("t1_one_txn", 64'(obs_q.size()), 64'd1);

        // simultaneous writes after reset: dbg first
        do_reset();
        mem_lat = 0; obs_q.delete();
        cpu_todo.push_back(mk(1'b1, 4'hF, 32'h10, 32'h1111_1111));
        dbg_todo.push_back(mk(1'b1, 4'hF, 32'h20, 32'h2222_2222));
        run_done(50);
        chk("t2_count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("t2_first", 64'(obs_q[0]), 64'h20);
            chk("t2_second", 64'(obs_q[1]), 64'h10);
        end

        // continuous contention alternates dbg, cpu, ...
        do_reset();
        obs_q.delete();
        for (int i = 0; i < 3; i++) begin
            cpu_todo.push_back(mk(1'b0, 4'hF, 32'h100 + 32'(4*i), 32'h0));
            dbg_todo.push_back(mk(1'b0, 4'hF, 32'h200 + 32'(4*i), 32'h0));
            exp_pat[2*i]   = 32'h200 + 32'(4*i);
            exp_pat[2*i+1] = 32'h100 + 32'(4*i);
        end
        run_done(100);
        chk("t3_count", 64'(obs_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++)
            chk("t3_order", 64'(obs_q[i]), 64'(exp_pat[i]));

        // address change while waiting has no effect
        do_reset();
        mem_lat = 3; obs_q.delete();
        cpu_todo.push_back(mk(1'b0, 4'hF, 32'h40, 32'h0));
        tick(); tick();
        r_addr[0] = 32'h80;
        run_done(50);
        chk("t4_count", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() == 1) chk("t4_addr", 64'(obs_q[0]), 64'h40);

        // dbg drops stb before resp: transaction completes, resp still pulsed
        do_reset();
        r1 = n_resp[1];
        dbg_todo.push_back(mk(1'b0, 4'hF, 32'h300, 32'h0));
        tick(); tick();
        r_stb[1] = 1'b0;
        run_done(50);
        chk("t5_drop_resp", 64'(n_resp[1] - r1), 64'd1);

        // reset mid-transaction, late response ignored
        do_reset();
        mem_lat = 6;
        dbg_todo.push_back(mk(1'b1, 4'hF, 32'h500, 32'h5555_5555));
        tick(); tick(); tick();
        do_reset();
        r0 = n_resp[0]; r1 = n_resp[1];
        stray_now = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_cpu_resp", 64'(n_resp[0] - r0), 64'd0);
        chk("t6_no_dbg_resp", 64'(n_resp[1] - r1), 64'd0);

        // stray resp in idle, then partial byte-enable write and readback
        do_reset();
        r0 = n_resp[0]; r1 = n_resp[1];
        stray_now = 1'b1;
        tick(); tick();
        chk("t7_stray_cpu", 64'(n_resp[0] - r0), 64'd0);
        chk("t7_stray_dbg", 64'(n_resp[1] - r1), 64'd0);
        mem_lat = 1;
        cpu_todo.push_back(mk(1'b1, 4'b0011, 32'h600, 32'hCAFE_F00D));
        run_done(50);
        chk("t7_mbe", 64'(last_mbe), 64'h3);
        chk("t7_we", 64'(last_we), 64'd1);
        dbg_todo.push_back(mk(1'b0, 4'hF, 32'h600, 32'h0));
        run_done(50);
        chk("t7_readback", 64'(last_rdata[1]), 64'hA5A5_F00D);

        // randomized traffic
        do_reset();
        req_rand = 1; rand_lat = 1;
        for (int i = 0; i < 30; i++) begin
            cpu_todo.push_back(mk(1'($urandom), 4'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom));
            dbg_todo.push_back(mk(1'($urandom), 4'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom));
        end
        run_done(4000);
        req_rand = 0; rand_lat = 0;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        // DBG_PRIORITY=1: dbg wins every tie while it keeps requesting
        dcnt = 0;
        p_pat[0] = 32'h300; p_pat[1] = 32'h304; p_pat[2] = 32'h308; p_pat[3] = 32'h400;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            p_rst = 0;
            p_cpu_stb = 1; p_cpu_address = 32'h400;
            p_dbg_stb = (dcnt < 3);
            p_dbg_address = 32'h300 + 32'(4*dcnt);
            p_mem_resp = p_mem_stb;
            p_mem_rdata = $urandom;
            #1;
            if (p_mem_stb === 1'b1) plog.push_back(p_mem_address);
            if (p_dbg_resp === 1'b1) dcnt++;
        end
        chk("prio_count", 64'(plog.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < plog.size(); i++)
            chk("prio_order", 64'(plog[i]), 64'(p_pat[i]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_mem_arbiter.md
Name: dm_mem_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single memory port between the core's data port and the debug module's master port (dmm_*).
- Sits between the debugger top and the memory model; both requesters use the stb/we/mbe/address/wdata -> resp/rdata handshake.
- Grants one requester at a time and registers its request onto the memory port.
- Routes the single-cycle memory response back to the granted requester only.

Parameters:
- S_OFFSET, 2: log2 bytes per line.
- S_MASK, 2**S_OFFSET: byte-enable width.
- S_LINE, 8*S_MASK: data width.
- DBG_PRIORITY, 0: 0 = round-robin between cpu and dbg; 1 = dbg always wins simultaneous requests.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- cpu_stb  in  1  core request strobe, held until cpu_resp
- cpu_we  in  1  core write enable
- cpu_mbe  in  S_MASK  core byte enables
- cpu_address  in  32  core address
- cpu_wdata  in  S_LINE  core write data
- cpu_resp  out  1  core response pulse
- cpu_rdata  out  S_LINE  core read data
- dbg_stb, dbg_we, dbg_mbe, dbg_address, dbg_wdata  in  1/1/S_MASK/32/S_LINE  debug master request (from dmm_*)
- dbg_resp  out  1  debug response pulse (drives dmm_resp)
- dbg_rdata  out  S_LINE  debug read data
- mem_stb  out  1  memory strobe
- mem_we  out  1  memory write enable
- mem_mbe  out  S_MASK  memory byte enables
- mem_address  out  32  memory address
- mem_wdata  out  S_LINE  memory write data
- mem_resp  in  1  memory response, one cycle per transaction
- mem_rdata  in  S_LINE  memory read data, valid with mem_resp

Behaviour:
- Reset (rst_i high at a clock edge):
  - State = IDLE; last_grant = CPU, so dbg is favoured on the first tie in round-robin mode.
  - mem_stb, mem_we = 0; mem_mbe, mem_address, mem_wdata = 0.
  - cpu_resp, dbg_resp = 0.
- States: IDLE, GNT_CPU, GNT_DBG.
- IDLE:
  - Neither stb high -> stay in IDLE.
  - Only one stb high -> grant that requester.
  - Both high -> DBG_PRIORITY=1 grants dbg; DBG_PRIORITY=0 grants the requester other than last_grant.
  - On grant: capture we/mbe/address/wdata into the mem_* registers, set mem_stb=1 on the next cycle, update last_grant.
- GNT_x:
  - mem_* outputs are held stable from registers, with no combinational dependence on requester inputs.
  - When mem_resp=1: x_resp=1 combinationally in the same cycle; x_rdata = mem_rdata.
  - The edge that samples mem_resp returns the state to IDLE and clears mem_stb, so mem_stb is low the cycle after mem_resp.
- Latency:
  - stb first high at cycle N in IDLE -> mem_stb high at N+1.
  - mem_resp at cycle M -> x_resp at M.
  - A back-to-back request (stb still high at M+1) is re-arbitrated in IDLE at M+1, so mem_stb is high again at M+2.
  - The minimum gap between memory transactions is one idle cycle.
- Response routing:
  - The non-granted requester's resp is always 0.
  - cpu_rdata and dbg_rdata both mirror mem_rdata at all times; it is qualified only by the respective resp.
  - mem_resp while in IDLE is ignored; no resp is asserted.
- Requester drops stb before resp (protocol violation):
  - The memory transaction runs to completion.
  - resp is still pulsed to the owner.
  - No abort is issued on the memory side.
- Requester changes address or wdata while waiting: no effect, because values were captured at grant.
- Fairness: in round-robin mode, with both requesters continuously asserting, grants strictly alternate dbg, cpu, dbg, ...
- Reset mid-transaction: mem_stb drops on the next cycle. A later mem_resp from the aborted transaction arrives in IDLE and is ignored.

Test Plan:
- Single cpu read:
  - Stimulus: cpu_stb=1, we=0, address=0x0000_0100 at cycle 0; memory returns mem_resp at cycle 3 with rdata=0xDEADBEEF.
  - Required: mem_stb high cycles 1-3, mem_address=0x100, cpu_resp=1 only at cycle 3 with cpu_rdata=0xDEADBEEF, dbg_resp=0 throughout.
- Simultaneous requests, DBG_PRIORITY=0, straight after reset:
  - Stimulus: cpu and dbg writes (addresses 0x10 and 0x20, mbe=4'b1111), one-cycle memory.
  - Required: the dbg write (0x20) is issued first, the cpu write (0x10) next; the memory sees exactly two strobes, one idle cycle apart.
- Continuous contention:
  - Stimulus: both stb held high for 6 transactions.
  - Required: RR mode alternates grants dbg,cpu,dbg,cpu,dbg,cpu; DBG_PRIORITY=1 gives dbg all grants while dbg_stb stays high.
- Request stability:
  - Stimulus: cpu_address changes from 0x40 to 0x80 while waiting for mem_resp.
  - Required: mem_address stays 0x40 until mem_resp.
- Reset mid-transaction:
  - Stimulus: rst_i=1 while in GNT_DBG, then mem_resp=1 arrives one cycle after reset is released.
  - Required: mem_stb=0 the cycle after reset; no dbg_resp or cpu_resp; state IDLE.
- Stray/partial mbe:
  - Stimulus: mem_resp asserted in IDLE with no request.
  - Required: no resp outputs asserted.
  - Stimulus: cpu write with mbe=4'b0011.
  - Required: mem_mbe=4'b0011 and mem_we=1 on the memory side.
